// File: rtl/spec_readout_tx_if.sv
// Bundle between the spectrum readout transmitter and its neighbours.
// It carries two groups of signals:
//   - accumulator RAM read port: rd_en_o, rd_addr_o (requests), rd_data_i
//     (data returned RD_LAT clocks after the request)
//   - host capture stream: y0_o / y0z_o (upper / lower 16 bits of a 32-bit
//     word) qualified by data_valid_o
// Stream semantics: a word is transferred on every clock where
// data_valid_o=1. There is no back-pressure. When data_valid_o=0, y0_o and
// y0z_o are held at 0.
// master = transmitter side, slave = RAM + capture side.
interface spec_readout_tx_if #(
    parameter int ADDR_W = 9,
    parameter int ACC_W  = 48
);
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [ACC_W-1:0]  rd_data_i;
    logic [15:0]       y0_o;
    logic [15:0]       y0z_o;
    logic              data_valid_o;

    modport master (
        output rd_en_o, rd_addr_o, y0_o, y0z_o, data_valid_o,
        input  rd_data_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, y0_o, y0z_o, data_valid_o,
        output rd_data_i
    );
endinterface

// File: rtl/spec_readout_tx.sv
// Spectrum readout transmitter.
// After each accumulation frame it reads the accumulator RAM from bin 0
// upward. Each bin is right-shifted and saturated to 32 bits. The bins are
// streamed as one word per clock, preceded by a 2-word header:
//   header 0 = {SYNC_HI, SYNC_LO}
//   header 1 = {frame counter, N_POINTS[15:0]}
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       frame-complete pulse
//   shift_i       right shift; values above 16 act as 16; sampled with start_i
//   bus           RAM read port and output stream (spec_readout_tx_if.master)
//   busy_o        frame in progress
//   done_o        one-cycle pulse after the last word
//   overrun_o     start_i seen while busy; combinational, same cycle as start_i
//   frame_cnt_o   frames fully transmitted (16-bit, wraps)
//   state_o       current FSM state (IDLE=0, READ=1, DRAIN=2)
// ACC_W must be greater than 32.
module spec_readout_tx #(
    parameter int          N_POINTS = 512,
    parameter int          ADDR_W   = 9,
    parameter int          ACC_W    = 48,
    parameter int          RD_LAT   = 2,
    parameter logic [15:0] SYNC_HI  = 16'hA5A5,
    parameter logic [15:0] SYNC_LO  = 16'h5A5A
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  shift_i,
    spec_readout_tx_if.master bus,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic [15:0] frame_cnt_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // cnt_q holds the current cycle number within the frame. Cycle 0 is the
    // start_i cycle. The largest value is 65535 + 4 + 2, so 18 bits suffice.
    localparam int CNT_W = 18;
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(N_POINTS);
    localparam logic [CNT_W-1:0] HDR0    = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] HDR1    = CNT_W'(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_DV = CNT_W'(RD_LAT + N_POINTS + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        shift_q, shift_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              dv_q, dv_d;
    logic [31:0]       word_q, word_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [ACC_W-1:0]  shifted;
    logic [31:0]       sat_word;

    // The shift is latched at start. It is never needed in the start cycle
    // itself, because the first data word comes out at cycle RD_LAT+2 or later.
    always_comb begin
        shifted  = bus.rd_data_i >> shift_q;
        sat_word = (|shifted[ACC_W-1:32]) ? 32'hFFFF_FFFF : shifted[31:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q + 16'(done_q);

        case (state_q)
            IDLE: begin
                // In the done_o cycle the FSM is already IDLE. A start there
                // still counts as busy and is rejected.
                if (start_i && !done_q) begin
                    state_d = READ;
                    cnt_d   = CNT_W'(1);
                    shift_d = (shift_i > 5'd16) ? 5'd16 : shift_i;
                end
            end
            READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_RD) state_d = DRAIN;
            end
            DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DV) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // All outputs are registered. They are derived from the next cycle number.
        rd_en_d   = (state_d == READ);
        rd_addr_d = rd_en_d ? ADDR_W'(cnt_d - CNT_W'(1)) : rd_addr_q;
        busy_d    = (state_d != IDLE);
        dv_d      = busy_d && (cnt_d >= HDR0);

        word_d = 32'h0;
        if (dv_d) begin
            if (cnt_d == HDR0)      word_d = {SYNC_HI, SYNC_LO};
            else if (cnt_d == HDR1) word_d = {frame_cnt_q, 16'(N_POINTS)};
            else                    word_d = sat_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            dv_q        <= 1'b0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            dv_q        <= dv_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.rd_en_o      = rd_en_q;
    assign bus.rd_addr_o    = rd_addr_q;
    assign bus.data_valid_o = dv_q;
    assign bus.y0_o         = word_q[31:16];
    assign bus.y0z_o        = word_q[15:0];
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign state_o          = state_q;
    assign overrun_o        = start_i && !rst_i && (busy_q || done_q);
endmodule

// File: tb/tb_spec_readout_tx.sv
`timescale 1ns/1ps
module tb_spec_readout_tx;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 48;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [4:0]  shift_i;
    logic        busy_o, done_o, overrun_o;
    logic [15:0] frame_cnt_o;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    logic [31:0]   exp_q[$];
    logic [31:0]   exp_words[N];
    logic [31:0]   mon_exp;
    logic [DW-1:0] ram[N];
    logic [DW-1:0] p1 = '0;
    logic [DW-1:0] p2 = '0;

    // clock / reset block
    always #5 clk = ~clk;

    spec_readout_tx_if #(.ADDR_W(AW), .ACC_W(DW)) bus();

    spec_readout_tx #(
        .N_POINTS(N), .ADDR_W(AW), .ACC_W(DW), .RD_LAT(2),
        .SYNC_HI(16'hA5A5), .SYNC_LO(16'h5A5A)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .shift_i(shift_i),
        .bus(bus), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
        .frame_cnt_o(frame_cnt_o), .state_o(state_o)
    );

    // RAM model with a 2-clock read latency
    always @(posedge clk) begin
        p1 <= bus.rd_en_o ? ram[bus.rd_addr_o] : '0;
        p2 <= p1;
    end
    assign bus.rd_data_i = p2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.data_valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_extra got=%0h exp=none at %0t", {bus.y0_o, bus.y0z_o}, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("stream_word", {32'h0, bus.y0_o, bus.y0z_o}, {32'h0, mon_exp});
            end
        end else begin
            check("idle_zero", {32'h0, bus.y0_o, bus.y0z_o}, 64'h0);
        end
    end

    // Driver. On entry the bench is in cycle 0, just after the clock edge.
    // The task returns in cycle 13, just after the edge, so a following call
    // starts back-to-back.
    task automatic run_frame(input logic [4:0] sh, input logic [15:0] fc, input int ov_cycle);
        exp_q.push_back(32'hA5A5_5A5A);
        exp_q.push_back({fc, 16'h0008});
        for (int i = 0; i < N; i++) exp_q.push_back(exp_words[i]);
        start_i = 1'b1;
        shift_i = sh;
        @(negedge clk);
        check("pre_busy", {63'h0, busy_o}, 64'h0);
        check("pre_frame_cnt", {48'h0, frame_cnt_o}, {48'h0, fc});
        check("pre_overrun", {63'h0, overrun_o}, 64'h0);
        @(posedge clk); #1;
        start_i = 1'b0;
        shift_i = ~sh;
        for (int k = 1; k <= 12; k++) begin
            start_i = (k == ov_cycle);
            @(negedge clk);
            check("rd_en", {63'h0, bus.rd_en_o}, {63'h0, k <= N});
            if (k <= N) check("rd_addr", {61'h0, bus.rd_addr_o}, 64'(k - 1));
            else        check("rd_addr_hold", {61'h0, bus.rd_addr_o}, 64'(N - 1));
            check("busy", {63'h0, busy_o}, {63'h0, k <= 11});
            check("done", {63'h0, done_o}, {63'h0, k == 12});
            check("overrun", {63'h0, overrun_o}, {63'h0, k == ov_cycle});
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        check("q_empty", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        shift_i = 5'd0;
        for (int i = 0; i < N; i++) ram[i] = DW'(i * 1000);

        // reset with start_i toggling; start_i and rst_i are high together on the last edge
        for (int k = 0; k < 3; k++) begin
            start_i = (k != 1);
            @(posedge clk);
            @(negedge clk);
            check("rst_rd_en", {63'h0, bus.rd_en_o}, 64'h0);
            check("rst_busy", {63'h0, busy_o}, 64'h0);
            check("rst_done", {63'h0, done_o}, 64'h0);
            check("rst_overrun", {63'h0, overrun_o}, 64'h0);
            check("rst_frame_cnt", {48'h0, frame_cnt_o}, 64'h0);
            check("rst_state", {62'h0, state_o}, 64'h0);
        end
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", {63'h0, busy_o}, 64'h0);
        check("post_rst_rd_en", {63'h0, bus.rd_en_o}, 64'h0);
        @(posedge clk); #1;

        // basic frame: RAM[a] = a*1000, shift 0
        for (int i = 0; i < N; i++) exp_words[i] = 32'(i * 1000);
        run_frame(5'd0, 16'h0000, 0);
        // back-to-back start at cycle 13, plus a rejected start at cycle 5
        run_frame(5'd0, 16'h0001, 5);
        // a start in the done cycle (12) must be rejected
        run_frame(5'd0, 16'h0002, 12);

        // scaling / saturation
        ram[0] = 48'h0001_0000_0000;
        ram[1] = 48'hFFFF_FFFF_FFFF;
        ram[2] = 48'h0000_0001_0000;
        ram[3] = 48'h0000_1234_5678;
        ram[4] = 48'h0000_FFFF_FFFF;
        ram[5] = 48'h0000_0000_0000;
        ram[6] = 48'h8000_0000_0000;
        ram[7] = 48'h0001_FFFF_FFFF;
        exp_words = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'h1234_5678,
                      32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_frame(5'd0, 16'h0003, 0);
        exp_words = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1234,
                      32'h0000_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h0001_FFFF};
        run_frame(5'd16, 16'h0004, 0);
        run_frame(5'd31, 16'h0005, 0);

        // reset mid-frame at cycle 6: only the words up to cycle 6 come out
        exp_q.push_back(32'hA5A5_5A5A);
        exp_q.push_back(32'h0006_0008);
        exp_q.push_back(32'h0001_0000);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0001);
        start_i = 1'b1;
        shift_i = 5'd16;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int k = 7; k <= 20; k++) begin
            @(negedge clk);
            check("abort_done", {63'h0, done_o}, 64'h0);
            check("abort_busy", {63'h0, busy_o}, 64'h0);
            check("abort_rd_en", {63'h0, bus.rd_en_o}, 64'h0);
            check("abort_frame_cnt", {48'h0, frame_cnt_o}, 64'h0);
            @(posedge clk); #1;
        end
        check("abort_q_empty", 64'(exp_q.size()), 64'h0);
        run_frame(5'd16, 16'h0000, 0);

        // counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        run_frame(5'd16, 16'hFFFF, 0);
        @(negedge clk);
        check("frame_cnt_wrap", {48'h0, frame_cnt_o}, 64'h0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
